// File: rtl/dec_sweep_checker.sv
// Sweeps all 4-bit codes into a 4-to-16 decoder under test and grades its D output
// against the ideal one-hot value, recording fault map, count and first failure.
module dec_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        W,
    input  logic [15:0] D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fault_count,
    output logic [15:0] fault_map,
    output logic [3:0]  first_fail_code,
    output logic [15:0] first_fail_d,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t      state_q;
    logic [3:0]  code_q;
    logic [3:0]  settle_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [4:0]  fault_count_q;
    logic [4:0]  fault_count_d;
    logic [15:0] fault_map_q;
    logic [3:0]  first_fail_code_q;
    logic [15:0] first_fail_d_q;
    logic [15:0] expected_d;
    logic        sample;
    logic        mismatch;

    // Handshake: start is a level request with no ready; it is only sampled in IDLE,
    // and any assertion while RUN or FIN is dropped (no queueing).
    assign expected_d = 16'h0001 << code_q;
    assign sample     = (state_q == RUN) && (settle_q == 4'd1);
    assign mismatch   = (D != expected_d);

    always_comb begin
        fault_count_d = fault_count_q;
        if (sample && mismatch && (fault_count_q != 5'd16)) begin
            fault_count_d = fault_count_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            code_q            <= 4'd0;
            settle_q          <= 4'd0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            fault_count_q     <= 5'd0;
            fault_map_q       <= 16'h0000;
            first_fail_code_q <= 4'd0;
            first_fail_d_q    <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        fault_count_q     <= 5'd0;
                        fault_map_q       <= 16'h0000;
                        first_fail_code_q <= 4'd0;
                        first_fail_d_q    <= 16'h0000;
                        pass_q            <= 1'b0;
                        code_q            <= 4'd0;
                        settle_q          <= SETTLE_L;
                        busy_q            <= 1'b1;
                        state_q           <= RUN;
                    end
                end
                RUN: begin
                    if (sample) begin
                        fault_count_q <= fault_count_d;
                        if (mismatch) begin
                            fault_map_q[code_q] <= 1'b1;
                            // Count still zero means this is the sweep's first fault.
                            if (fault_count_q == 5'd0) begin
                                first_fail_code_q <= code_q;
                                first_fail_d_q    <= D;
                            end
                        end
                        if (code_q == 4'd15) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (fault_count_d == 5'd0);
                            state_q <= FIN;
                        end else begin
                            code_q   <= code_q + 4'd1;
                            settle_q <= SETTLE_L;
                        end
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {X, Y, Z, W}    = code_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fault_count     = fault_count_q;
    assign fault_map       = fault_map_q;
    assign first_fail_code = first_fail_code_q;
    assign first_fail_d    = first_fail_d_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_dec_sweep_checker.sv
// Directed bench for dec_sweep_checker: a stuck-at decoder model feeds D, and two
// instances (SETTLE=2 and SETTLE=1) are graded against hand-computed results.
module tb_dec_sweep_checker;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic        x0, y0, z0, w0, x1, y1, z1, w1;
  logic [15:0] d0, d1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [4:0]  fc0, fc1;
  logic [15:0] fmap0, fmap1, ffd0, ffd1;
  logic [3:0]  ffc0, ffc1;
  logic [1:0]  st0, st1;

  logic [15:0] sa0, sa1;
  int          checks;
  int          failures;
  int          sel;

  logic [3:0]  o_code;
  logic        o_busy, o_done, o_pass;
  logic [4:0]  o_fc;
  logic [15:0] o_fmap, o_ffd;
  logic [3:0]  o_ffc;
  logic [1:0]  o_st;

  dec_sweep_checker #(.SETTLE(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .X(x0), .Y(y0), .Z(z0), .W(w0), .D(d0),
    .busy(busy0), .done(done0), .pass(pass0), .fault_count(fc0),
    .fault_map(fmap0), .first_fail_code(ffc0), .first_fail_d(ffd0),
    .dbg_state(st0)
  );

  dec_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .X(x1), .Y(y1), .Z(z1), .W(w1), .D(d1),
    .busy(busy1), .done(done1), .pass(pass1), .fault_count(fc1),
    .fault_map(fmap1), .first_fail_code(ffc1), .first_fail_d(ffd1),
    .dbg_state(st1)
  );

  // Decoder model with stuck-at-0 / stuck-at-1 masks on its outputs.
  logic [3:0]  code0_w, code1_w;
  logic [15:0] one = 16'h0001;
  assign code0_w = {x0, y0, z0, w0};
  assign code1_w = {x1, y1, z1, w1};
  assign d0 = ((one << code0_w) & ~sa0) | sa1;
  assign d1 = ((one << code1_w) & ~sa0) | sa1;

  always_comb begin
    if (sel == 1) begin
      o_code = code1_w; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_fc = fc1; o_fmap = fmap1; o_ffc = ffc1; o_ffd = ffd1; o_st = st1;
    end else begin
      o_code = code0_w; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_fc = fc0; o_fmap = fmap0; o_ffc = ffc0; o_ffd = ffd0; o_st = st0;
    end
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_start(input logic v);
    if (sel == 1) start1 = v;
    else          start0 = v;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({o_code, o_busy, o_done, o_pass, o_fc, o_fmap, o_ffc, o_ffd, o_st} !== '0) begin
      failures++;
      $display("FAIL %s: code=%h busy=%b done=%b pass=%b fc=%0d map=%h ffc=%h ffd=%h st=%0d, required all 0",
               tag, o_code, o_busy, o_done, o_pass, o_fc, o_fmap, o_ffc, o_ffd, o_st);
    end
  endtask

  // Full sweep with per-cycle code/busy/done checks and final result checks.
  task automatic do_sweep(input string tag, input int restart_at, input logic done_start,
                          input logic [15:0] e_map, input logic [4:0] e_cnt,
                          input logic [3:0] e_ffc, input logic [15:0] e_ffd);
    int s;
    s = (sel == 1) ? 1 : 2;
    drive_start(1'b1);
    @(negedge clk);
    for (int k = 0; k < 16 * s; k++) begin
      drive_start(k == restart_at);
      checks++;
      if (o_code !== 4'(k / s) || o_busy !== 1'b1 || o_done !== 1'b0) begin
        failures++;
        $display("FAIL %s_seq k=%0d: code=%h busy=%b done=%b, required code=%h busy=1 done=0",
                 tag, k, o_code, o_busy, o_done, 4'(k / s));
      end
      @(negedge clk);
    end
    drive_start(done_start);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_st !== 2'd2) begin
      failures++;
      $display("FAIL %s_done: done=%b busy=%b st=%0d, required 1 0 2", tag, o_done, o_busy, o_st);
    end
    checks++;
    if (o_fmap !== e_map || o_fc !== e_cnt || o_ffc !== e_ffc || o_ffd !== e_ffd ||
        o_pass !== (e_cnt == 5'd0)) begin
      failures++;
      $display("FAIL %s_results: map=%h cnt=%0d ffc=%h ffd=%h pass=%b, required %h %0d %h %h %b",
               tag, o_fmap, o_fc, o_ffc, o_ffd, o_pass, e_map, e_cnt, e_ffc, e_ffd, e_cnt == 5'd0);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_code !== 4'hF || o_fc !== e_cnt) begin
      failures++;
      $display("FAIL %s_after: done=%b busy=%b code=%h cnt=%0d, required 0 0 f %0d",
               tag, o_done, o_busy, o_code, o_fc, e_cnt);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b0;
    #12;
    check_zero("reset0");
    sel = 1;
    check_zero("reset1");
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_release");
  endtask

  task automatic test_ideal();
    sa0 = 16'h0000; sa1 = 16'h0000;
    do_sweep("ideal", -1, 1'b0, 16'h0000, 5'd0, 4'd0, 16'h0000);
  endtask

  task automatic test_stuck0();
    sa0 = 16'h0020; sa1 = 16'h0000;
    do_sweep("d5_sa0", -1, 1'b0, 16'h0020, 5'd1, 4'd5, 16'h0000);
  endtask

  task automatic test_stuck1();
    sa0 = 16'h0000; sa1 = 16'h0001;
    do_sweep("d0_sa1", -1, 1'b0, 16'hFFFE, 5'd15, 4'd1, 16'h0003);
  endtask

  task automatic test_restart_ignored();
    sa0 = 16'h0000; sa1 = 16'h0000;
    do_sweep("restart10", 10, 1'b0, 16'h0000, 5'd0, 4'd0, 16'h0000);
  endtask

  task automatic test_back_to_back();
    bit seen;
    sa0 = 16'h0020; sa1 = 16'h0000;
    do_sweep("b2b_first", -1, 1'b1, 16'h0020, 5'd1, 4'd5, 16'h0000);
    // start was high across the FIN edge (ignored) and stays high for the next edge.
    sa0 = 16'h0000;
    @(negedge clk);
    drive_start(1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_code !== 4'd0 || o_fc !== 5'd0 || o_fmap !== 16'h0000 ||
        o_ffc !== 4'd0 || o_pass !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b code=%h cnt=%0d map=%h ffc=%h pass=%b, required 1 0 0 0000 0 0",
               o_busy, o_code, o_fc, o_fmap, o_ffc, o_pass);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = o_done;
    end
    checks++;
    if (!seen || o_pass !== 1'b1 || o_fmap !== 16'h0000 || o_fc !== 5'd0) begin
      failures++;
      $display("FAIL b2b_second: seen_done=%b pass=%b map=%h cnt=%0d, required 1 1 0000 0",
               seen, o_pass, o_fmap, o_fc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    bit seen;
    sa0 = 16'h0000; sa1 = 16'h0001;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (o_code == 4'd7) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || o_fc !== 5'd6) begin
      failures++;
      $display("FAIL mid_reach7: seen=%b cnt=%0d, required 1 6", seen, o_fc);
    end
    #2 rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("mid_release");
    sa1 = 16'h0000;
    do_sweep("after_reset", -1, 1'b0, 16'h0000, 5'd0, 4'd0, 16'h0000);
  endtask

  task automatic test_settle1_all_ones();
    sel = 1;
    sa0 = 16'h0000; sa1 = 16'hFFFF;
    do_sweep("s1_ones", -1, 1'b0, 16'hFFFF, 5'd16, 4'd0, 16'hFFFF);
    sel = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sel = 0;
    start0 = 1'b0;
    start1 = 1'b0;
    sa0 = 16'h0000;
    sa1 = 16'h0000;
    rst_n = 1'b0;
    test_reset();
    test_ideal();
    test_stuck0();
    test_stuck1();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle1_all_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_sweep_checker.md
# dec_sweep_checker

Self-checking stimulus/response stage for the 4-to-16 decoder fault experiments. On a start request it drives every 4-bit code onto a decoder-under-test's X/Y/Z/W inputs and waits a programmable settle time. It then samples the 16-bit D output and compares it against the ideal one-hot value. It records a fault map, a fault count and the first failing code and pattern, so fault-injected decoder variants can be graded in simulation and on hardware without manual waveform inspection.

## Interface

**Parameters**
- SETTLE, default 2: cycles each code is held before D is sampled; legal range 1..15.

**Ports**
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: sweep request, sampled in IDLE only.
- X, output, 1: code bit 3 (MSB) to decoder, registered.
- Y, output, 1: code bit 2, registered.
- Z, output, 1: code bit 1, registered.
- W, output, 1: code bit 0 (LSB), registered.
- D, input, 16: decoder output under test.
- busy, output, 1: sweep in progress.
- done, output, 1: one-cycle pulse when the sweep completes.
- pass, output, 1: 1 when the last sweep had zero faults.
- fault_count, output, 5: number of failing codes, 0..16.
- fault_map, output, 16: bit n set when code n failed.
- first_fail_code, output, 4: lowest failing code.
- first_fail_d, output, 16: D value sampled for first_fail_code.

## Operation

**Code and expected value**
- code = {X,Y,Z,W}.
- Expected D for code n is 16'h0001 << n, exactly one bit high.
- Any other value is a fault, including all-zero or multi-hot.

**FSM**
- IDLE
  - X/Y/Z/W hold their last value (0 after reset).
  - start=1 → clear fault_count, fault_map, first_fail_code, first_fail_d and pass.
  - On the same start edge: load code 0, load settle counter to SETTLE, go to RUN.
- RUN
  - Settle counter decrements every cycle.
  - When it would reach 0, sample D and compare at that edge.
  - On a mismatch: set fault_map[code] and increment fault_count.
  - If this is the first fault of the sweep, capture first_fail_code and first_fail_d.
  - Same edge, code < 15: increment code and reload the counter to SETTLE.
  - Same edge, code = 15: go to FIN.
- FIN
  - Lasts one cycle: done=1, busy=0, pass = (fault_count==0).
  - Returns to IDLE.
  - X/Y/Z/W stay at 4'b1111 until the next start.

**Rules**
- busy=1 exactly while in RUN.
- start in RUN or FIN is ignored; no restart, no queueing.
- start in the first IDLE cycle after FIN is accepted normally.
- Result outputs hold their values from the end of a sweep until the next accepted start or reset.
- fault_count is 5 bits and never wraps; max is 16.
- Reset at any time (mid-sweep included):
  - Every output goes to 0 immediately: X,Y,Z,W,busy,done,pass,fault_count,fault_map,first_fail_code,first_fail_d.
  - FSM goes to IDLE and no partial results are retained.
- D is treated as synchronous to clk. The decoder is combinational, so no synchroniser is used.

## Timing

- start sampled high at edge t0: busy=1 and code 0 are visible after t0.
- Code n is driven from edge t0+n·SETTLE.
- Code n is sampled at edge t0+(n+1)·SETTLE.
- Last sample at t0+16·SETTLE, followed by the FIN state: done=1 after that edge for one cycle.
- Results are valid from that edge onward.
- Total sweep: 16·SETTLE cycles of busy, plus 1 done cycle.
- Earliest restart: start high during the done cycle is ignored; start high in the cycle after is accepted.
- fault_map, fault_count and first_fail_* update at sample edges, during the sweep.
- pass updates only at the FIN edge.

## Test plan

- **Ideal decoder model, SETTLE=2, start at t0**
  - Codes 0..15 each appear for 2 cycles.
  - done pulses one cycle after t0+32.
  - pass=1, fault_count=0, fault_map=16'h0000, first_fail_code=0, first_fail_d=16'h0000.
- **D[5] stuck-at-0**
  - fault_map=16'h0020, fault_count=1, first_fail_code=5, first_fail_d=16'h0000, pass=0.
- **D[0] stuck-at-1**
  - fault_map=16'hFFFE, fault_count=15, first_fail_code=1, first_fail_d=16'h0003, pass=0.
- **start pulsed again at t0+10 (SETTLE=2)**
  - No effect: code sequence, done timing and results are identical to the first scenario.
  - start asserted in the done cycle is also ignored.
  - start asserted in the next cycle begins a new sweep and clears the previous results.
- **rst_n low asynchronously while code 7 is driven**
  - All outputs read 0 immediately, FSM in IDLE, busy=0.
  - After release, a fresh start runs a full sweep with correct results.
- **SETTLE=1, all-ones D (every code multi-hot)**
  - done one cycle after t0+16.
  - fault_count=16, fault_map=16'hFFFF, first_fail_code=0, first_fail_d=16'hFFFF.
